// File: rtl/cpu_run_ctrl.sv
// Run controller for one stack CPU: streams a program image into program memory,
// holds the CPU in reset briefly, then runs it until halt or timeout.
module cpu_run_ctrl #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int RESET_HOLD     = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [DATA_WIDTH-1:0]  load_data,
  input  logic                   load_last,
  output logic                   prog_we,
  output logic [ADDR_WIDTH-1:0]  prog_addr,
  output logic [DATA_WIDTH-1:0]  prog_wdata,
  output logic                   cpu_rst,
  input  logic                   cpu_halt,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_HOLD = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0]      HOLD_LAST   = HOLD_W'(RESET_HOLD - 1);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);

  logic [2:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [COUNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic                   timeout_q, timeout_d;
  logic                   overflow_q, overflow_d;
  logic                   prog_we_q, prog_we_d;
  logic [ADDR_WIDTH-1:0]  prog_addr_q, prog_addr_d;
  logic [DATA_WIDTH-1:0]  prog_wdata_q, prog_wdata_d;
  logic                   load_ready_q, load_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic                   accept;

  assign accept = load_ready_q && load_valid;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_d        = hold_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    overflow_d    = overflow_q;
    prog_we_d     = 1'b0;
    prog_addr_d   = prog_addr_q;
    prog_wdata_d  = prog_wdata_q;

    // abort outranks everything, including a word handshaking in the same cycle
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d       = ST_LOAD;
            ptr_d         = '0;
            cycle_count_d = '0;
            timeout_d     = 1'b0;
            overflow_d    = 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            prog_we_d    = 1'b1;
            prog_addr_d  = ptr_q;
            prog_wdata_d = load_data;
            ptr_d        = ptr_q + 1'b1;
            if (load_last) begin
              state_d = ST_HOLD;
              hold_d  = '0;
            end else if (ptr_q == '1) begin
              overflow_d = 1'b1;
              state_d    = ST_DONE;
            end
          end
        end
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) state_d = ST_RUN;
          else hold_d = hold_q + 1'b1;
        end
        ST_RUN: begin
          if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 1'b1;
          // halt wins over a timeout reached in the same cycle
          if (cpu_halt) begin
            state_d = ST_DONE;
          end else if (cycle_count_d >= TIMEOUT_VAL) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    load_ready_d = (state_d == ST_LOAD);
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_HOLD) || (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
    cpu_rst_d    = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      hold_q        <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
      prog_we_q     <= 1'b0;
      prog_addr_q   <= '0;
      prog_wdata_q  <= '0;
      load_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cpu_rst_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      overflow_q    <= overflow_d;
      prog_we_q     <= prog_we_d;
      prog_addr_q   <= prog_addr_d;
      prog_wdata_q  <= prog_wdata_d;
      load_ready_q  <= load_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cpu_rst_q     <= cpu_rst_d;
    end
  end

  assign load_ready  = load_ready_q;
  assign prog_we     = prog_we_q;
  assign prog_addr   = prog_addr_q;
  assign prog_wdata  = prog_wdata_q;
  assign cpu_rst     = cpu_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;
  assign cycle_count = cycle_count_q;

endmodule
